// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencer. Owns the instruction-memory req/ack
// handshake, tells the PC when to advance or load a redirect target, and
// holds the fetched word (plus a one-entry skid) for the IF/ID register.
module fetch_ctrl #(
  parameter int                    WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] NOP_INST   = {WORD_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] i_pc_now,
  output logic                  o_pc_stall,
  output logic                  o_pc_src,
  output logic [WORD_WIDTH-1:0] o_pc_jumpaddr,
  input  logic                  i_redirect_valid,
  input  logic [WORD_WIDTH-1:0] i_redirect_addr,
  input  logic                  i_id_stall,
  output logic                  o_imem_req,
  output logic [WORD_WIDTH-1:0] o_imem_addr,
  input  logic                  i_imem_ack,
  input  logic [WORD_WIDTH-1:0] i_imem_rdata,
  output logic                  o_if_valid,
  output logic [WORD_WIDTH-1:0] o_if_inst,
  output logic [WORD_WIDTH-1:0] o_if_pc
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_SKID  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_if_valid;
  logic [WORD_WIDTH-1:0] r_if_inst;
  logic [WORD_WIDTH-1:0] r_if_pc;
  logic [WORD_WIDTH-1:0] r_skid_inst;
  logic [WORD_WIDTH-1:0] r_skid_pc;
  logic [WORD_WIDTH-1:0] r_drain_addr;

  logic w_buf_free;
  logic w_consume;

  assign o_if_valid = r_if_valid;
  assign o_if_inst  = r_if_inst;
  assign o_if_pc    = r_if_pc;

  // Handshake and PC controls; rst forces the idle values without waiting for an edge
  always_comb begin
    w_buf_free    = !r_if_valid || !i_id_stall;
    w_consume     = r_if_valid && !i_id_stall;
    o_pc_jumpaddr = i_redirect_addr;
    o_pc_src      = i_redirect_valid && !rst;
    o_imem_req    = 1'b0;
    o_imem_addr   = i_pc_now;
    o_pc_stall    = 1'b1;
    case (r_state)
      S_FETCH: begin
        o_imem_req = 1'b1;
        o_imem_addr = i_pc_now;
      end
      S_DRAIN: begin
        o_imem_req = 1'b1;
        o_imem_addr = r_drain_addr;
      end
      default: begin
        o_imem_req = 1'b0;
        o_imem_addr = i_pc_now;
      end
    endcase
    // A completed fetch lets the PC step; a redirect makes it load the target
    if (rst) begin
      o_pc_stall = 1'b1;
    end else if (i_redirect_valid) begin
      o_pc_stall = 1'b0;
    end else if (r_state == S_FETCH && i_imem_ack) begin
      o_pc_stall = 1'b0;
    end else begin
      o_pc_stall = 1'b1;
    end
  end

  // State machine plus the IF buffer, skid entry and drain address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_BOOT;
      r_if_valid   <= 1'b0;
      r_if_inst    <= NOP_INST;
      r_if_pc      <= {WORD_WIDTH{1'b0}};
      r_skid_inst  <= NOP_INST;
      r_skid_pc    <= {WORD_WIDTH{1'b0}};
      r_drain_addr <= {WORD_WIDTH{1'b0}};
    end else if (i_redirect_valid) begin
      // Everything fetched so far is on the wrong path
      r_if_valid  <= 1'b0;
      r_if_inst   <= NOP_INST;
      r_skid_inst <= NOP_INST;
      r_skid_pc   <= {WORD_WIDTH{1'b0}};
      case (r_state)
        S_FETCH: begin
          if (i_imem_ack) begin
            r_state <= S_FETCH;
          end else begin
            // The request cannot be withdrawn, so remember it and swallow its ack
            r_drain_addr <= i_pc_now;
            r_state      <= S_DRAIN;
          end
        end
        S_DRAIN: r_state <= i_imem_ack ? S_FETCH : S_DRAIN;
        default: r_state <= S_FETCH;
      endcase
    end else begin
      case (r_state)
        S_BOOT: r_state <= S_FETCH;
        S_FETCH: begin
          if (i_imem_ack && w_buf_free) begin
            r_if_inst  <= i_imem_rdata;
            r_if_pc    <= i_pc_now;
            r_if_valid <= 1'b1;
          end else if (i_imem_ack) begin
            // ID is stalled on a live word: park the new one behind it
            r_skid_inst <= i_imem_rdata;
            r_skid_pc   <= i_pc_now;
            r_state     <= S_SKID;
          end else if (w_consume) begin
            r_if_valid <= 1'b0;
            r_if_inst  <= NOP_INST;
          end else begin
            r_if_valid <= r_if_valid;
          end
        end
        S_SKID: begin
          if (w_buf_free) begin
            r_if_inst  <= r_skid_inst;
            r_if_pc    <= r_skid_pc;
            r_if_valid <= 1'b1;
            r_state    <= S_FETCH;
          end else begin
            r_state <= S_SKID;
          end
        end
        S_DRAIN: begin
          if (w_consume) begin
            r_if_valid <= 1'b0;
            r_if_inst  <= NOP_INST;
          end else begin
            r_if_valid <= r_if_valid;
          end
          r_state <= i_imem_ack ? S_FETCH : S_DRAIN;
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: models the PC register and a memory whose
// ack timing is driven by hand; instruction word = address ^ 32'hA5.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc_r;
  logic        pc_stall;
  logic        pc_src;
  logic [31:0] pc_jumpaddr;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        id_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;

  int n_pass;
  int n_chk;

  fetch_ctrl #(.WORD_WIDTH(32), .NOP_INST(32'h0)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_pc_now         (pc_r),
    .o_pc_stall       (pc_stall),
    .o_pc_src         (pc_src),
    .o_pc_jumpaddr    (pc_jumpaddr),
    .i_redirect_valid (redirect_valid),
    .i_redirect_addr  (redirect_addr),
    .i_id_stall       (id_stall),
    .o_imem_req       (imem_req),
    .o_imem_addr      (imem_addr),
    .i_imem_ack       (imem_ack),
    .i_imem_rdata     (imem_rdata),
    .o_if_valid       (if_valid),
    .o_if_inst        (if_inst),
    .o_if_pc          (if_pc)
  );

  assign imem_rdata = imem_addr ^ 32'hA5;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PC register controlled by the DUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_r <= 32'h0;
    else if (!pc_stall) pc_r <= pc_src ? pc_jumpaddr : pc_r + 32'd4;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass = 0;
    n_chk  = 0;
    rst = 1'b0; imem_ack = 1'b0; redirect_valid = 1'b0;
    redirect_addr = 32'h0; id_stall = 1'b0;
    #1 rst = 1'b1;
    step(); step();
    check("rst_req", imem_req, 32'd0);
    check("rst_stall", pc_stall, 32'd1);
    check("rst_valid", if_valid, 32'd0);
    check("rst_inst", if_inst, 32'h0);
    check("rst_pc", if_pc, 32'h0);

    // 1: ack tied high, one instruction per cycle
    imem_ack = 1'b1; rst = 1'b0; #1;
    check("boot_req", imem_req, 32'd0);
    check("boot_stall", pc_stall, 32'd1);
    step();
    check("f0_req", imem_req, 32'd1);
    check("f0_addr", imem_addr, 32'h0);
    check("f0_stall", pc_stall, 32'd0);
    check("f0_valid", if_valid, 32'd0);
    step();
    check("f1_valid", if_valid, 32'd1);
    check("f1_ifpc", if_pc, 32'h0);
    check("f1_inst", if_inst, 32'hA5);
    check("f1_stall", pc_stall, 32'd0);
    check("f1_addr", imem_addr, 32'h4);
    step();
    check("f2_ifpc", if_pc, 32'h4);
    check("f2_inst", if_inst, 32'hA1);
    step();
    check("f3_ifpc", if_pc, 32'h8);
    check("f3_stall", pc_stall, 32'd0);
    step();

    // 2: ack latency 3 at 0x10
    check("l_ifpc", if_pc, 32'hC);
    imem_ack = 1'b0; #1;
    check("l0_stall", pc_stall, 32'd1);
    check("l0_addr", imem_addr, 32'h10);
    step();
    check("l1_valid", if_valid, 32'd0);
    check("l1_inst", if_inst, 32'h0);
    check("l1_req", imem_req, 32'd1);
    check("l1_addr", imem_addr, 32'h10);
    check("l1_stall", pc_stall, 32'd1);
    step();
    check("l2_addr", imem_addr, 32'h10);
    check("l2_stall", pc_stall, 32'd1);
    step();
    imem_ack = 1'b1; #1;
    check("l3_addr", imem_addr, 32'h10);
    check("l3_stall", pc_stall, 32'd0);
    step();
    check("l4_valid", if_valid, 32'd1);
    check("l4_ifpc", if_pc, 32'h10);
    check("l4_inst", if_inst, 32'hB5);

    // 3: ID stalls while 0x14 returns -> skid
    id_stall = 1'b1; #1;
    check("s0_addr", imem_addr, 32'h14);
    check("s0_stall", pc_stall, 32'd0);
    step();
    imem_ack = 1'b0; #1;
    check("s1_req", imem_req, 32'd0);
    check("s1_stall", pc_stall, 32'd1);
    check("s1_ifpc", if_pc, 32'h10);
    step();
    check("s2_req", imem_req, 32'd0);
    check("s2_ifpc", if_pc, 32'h10);
    step();
    id_stall = 1'b0; #1;
    check("s3_ifpc", if_pc, 32'h10);
    check("s3_stall", pc_stall, 32'd1);
    step();
    check("s4_ifpc", if_pc, 32'h14);
    check("s4_inst", if_inst, 32'hB1);
    check("s4_req", imem_req, 32'd1);
    check("s4_addr", imem_addr, 32'h18);
    imem_ack = 1'b1;
    step();
    check("s5_ifpc", if_pc, 32'h18);
    step();

    // 4: redirect to 0x100 while 0x20 outstanding, ack two cycles later
    check("r_ifpc", if_pc, 32'h1C);
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_addr = 32'h100; #1;
    check("r0_src", pc_src, 32'd1);
    check("r0_stall", pc_stall, 32'd0);
    check("r0_jump", pc_jumpaddr, 32'h100);
    check("r0_addr", imem_addr, 32'h20);
    step();
    redirect_valid = 1'b0; #1;
    check("r1_valid", if_valid, 32'd0);
    check("r1_inst", if_inst, 32'h0);
    check("r1_req", imem_req, 32'd1);
    check("r1_addr", imem_addr, 32'h20);
    check("r1_src", pc_src, 32'd0);
    check("r1_stall", pc_stall, 32'd1);
    step();
    imem_ack = 1'b1; #1;
    check("r2_addr", imem_addr, 32'h20);
    step();
    check("r3_valid", if_valid, 32'd0);
    check("r3_addr", imem_addr, 32'h100);

    // 5: redirect to 0x200 in the same cycle as ack for 0x100
    redirect_valid = 1'b1; redirect_addr = 32'h200; #1;
    check("a0_src", pc_src, 32'd1);
    check("a0_stall", pc_stall, 32'd0);
    step();
    redirect_valid = 1'b0; imem_ack = 1'b0; #1;
    check("a1_valid", if_valid, 32'd0);
    check("a1_req", imem_req, 32'd1);
    check("a1_addr", imem_addr, 32'h200);

    // 6: redirect into DRAIN, then reset mid-DRAIN
    redirect_valid = 1'b1; redirect_addr = 32'h300; #1;
    step();
    redirect_valid = 1'b0; #1;
    check("d0_req", imem_req, 32'd1);
    check("d0_addr", imem_addr, 32'h200);
    #2 rst = 1'b1; #1;
    check("x_req", imem_req, 32'd0);
    check("x_stall", pc_stall, 32'd1);
    check("x_valid", if_valid, 32'd0);
    check("x_src", pc_src, 32'd0);
    step(); step();
    rst = 1'b0; #1;
    check("x_boot_req", imem_req, 32'd0);
    check("x_boot_stall", pc_stall, 32'd1);
    step();
    check("x_f_req", imem_req, 32'd1);
    check("x_f_addr", imem_addr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
